probe_display_ctrl: RTL
=======================

// Module: probe_display_ctrl
// PURPOSE
//  Parametrised debug display: captures a 16-bit tag (e.g. PC) plus a selectable 16-bit window of one of NUM_CH probe words.
//  Scans the result onto an 8-digit multiplexed 7-seg display.
//  Also generates the single-cycle step_en clock-enable that paces the processor, so no derived clocks are needed.
//  Adds freeze/hold and out-of-range indication.
// PARAMETERS
//  NUM_CH   8            number of probe channels (>=1)
//  DATA_W   32           width of each probe word; multiple of 16
//  CLK_HZ   100000000    clk frequency
//  SCAN_HZ  5000         per-digit refresh rate; SCAN_DIV = CLK_HZ/SCAN_HZ (>=2)
//  STEP_HZ  1            step_en rate; STEP_DIV = CLK_HZ/STEP_HZ (>=2)
//  Derived: CH_W = max(1,clog2(NUM_CH)), WIN_W = max(1,clog2(DATA_W/16))
// PORTS
//  clk        in   1              system clock
//  reset      in   1              asynchronous, active-high
//  tag        in   16             shown on digits 0-3 (leftmost)
//  probe_bus  in   NUM_CH*DATA_W  channel k = probe_bus[k*DATA_W +: DATA_W]
//  ch_sel     in   CH_W           channel select
//  win_sel    in   WIN_W          16-bit window select; window w = bits [w*16 +: 16]
//  freeze     in   1              1 = hold displayed value
//  step_en    out  1              one-cycle pulse every STEP_DIV clks
//  LEDSEL     out  8              digit enables, active-low, one-hot; bit i = digit i
//  LEDOUT     out  8              segments, active-low {dp,g,f,e,d,c,b,a}
// BEHAVIOUR
//  Reset (async): scan_cnt=0, step_cnt=0, dig_idx=0, disp_reg=0, step_en=0, LEDSEL=8'hFF, LEDOUT=8'hFF (blank).
//  Capture register disp_reg[31:0] = {tag, window}:
//   - Loads every clk edge when freeze=0; holds when freeze=1.
//   - freeze wins over an input change on the same edge, so the held value is the one captured at the previous edge.
//   - Out-of-range select: ch_sel>=NUM_CH -> window=16'hDEAD; win_sel>=DATA_W/16 -> window=16'h0000. Channel check first.
//  Scan:
//   - scan_cnt counts 0..SCAN_DIV-1 and wraps; scan_tick = (scan_cnt==SCAN_DIV-1).
//   - On the edge where scan_tick=1: LEDSEL <= ~(8'b1<<dig_idx); LEDOUT <= seg(nibble dig_idx of disp_reg);
//     dig_idx <= dig_idx+1, wrapping 7->0.
//   - Digit i shows disp_reg[31-4i -: 4]; digit 0 = tag[15:12], digit 7 = window[3:0].
//   - LEDSEL and LEDOUT change only together, on scan_tick edges; otherwise held.
//   - First tick after reset lights digit 0 (display blank before that).
//  seg() active-low with dp=1:
//   0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E
//  Step:
//   - step_cnt counts 0..STEP_DIV-1 and wraps.
//   - step_en is registered: high for exactly the one cycle after step_cnt==STEP_DIV-1, so the first pulse is in cycle STEP_DIV after reset release.
//   - step_en is unaffected by freeze.
//  Reset mid-scan or mid-step: outputs blank and step_en=0 immediately; counters restart from 0.
//  All counters are free-running.
//  Data latency: input -> disp_reg 1 clk; disp_reg -> LEDOUT at next scan_tick for the digit addressed.
// TESTING  (CLK_HZ=80, SCAN_HZ=8 -> SCAN_DIV=10; STEP_HZ=10 -> STEP_DIV=8)
//  1 Reset, then release.
//    -> LEDSEL=FF and LEDOUT=FF for 9 clks.
//    -> At clk 10: LEDSEL=FE; the next 7 ticks give FD,FB,...,7F, then back to FE.
//  2 tag=16'h1234, ch 3 = 32'hCAFE_BEEF, ch_sel=3, win_sel=1.
//    -> Digits 0-7 show LEDOUT F9,A4,B0,99,C6,88,8E,86 (1,2,3,4,C,A,F,E).
//  3 Same setup with win_sel=0.
//    -> Digits 4-7 show 83,86,86,8E (b,E,E,F).
//  4 Raise freeze, change tag to 16'hFFFF and the channel data.
//    -> Display unchanged for a full scan.
//    -> Drop freeze: digit 0 shows 8E on its next tick.
//  5 NUM_CH=6, ch_sel=7.
//    -> Window digits show A1,86,88,A1 (DEAD).
//  6 Count step_en over 80 clks.
//    -> Exactly 10 one-cycle pulses, 8 clks apart.
//    -> Assert reset mid-period: step_en=0 and LEDSEL=FF in the same cycle.

Source files
------------

// File: rtl/probe_display_ctrl.sv
// Debug display: captures {tag, 16-bit probe window} and scans it onto an 8-digit 7-seg display; also paces the core with step_en.
// Latency: inputs -> disp_reg 1 clk; disp_reg -> LEDOUT at the next scan tick for that digit; step_en registered.
// Backpressure: none; all counters free-run and freeze only holds the capture register.
//
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   tag             16-bit value shown on digits 0-3
//   probe_bus       NUM_CH probe words, channel k = probe_bus[k*DATA_W +: DATA_W]
//   ch_sel, win_sel channel and 16-bit window select
//   freeze          1 = hold the captured value
//   step_en         one-cycle pulse every STEP_DIV clocks
//   LEDSEL, LEDOUT  active-low digit enables / segments {dp,g,f,e,d,c,b,a}
module probe_display_ctrl #(
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 32,
  parameter int CLK_HZ  = 100000000,
  parameter int SCAN_HZ = 5000,
  parameter int STEP_HZ = 1,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WIN_W  = ((DATA_W / 16) > 1) ? $clog2(DATA_W / 16) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [15:0]              tag,
  input  logic [NUM_CH*DATA_W-1:0] probe_bus,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic [WIN_W-1:0]         win_sel,
  input  logic                     freeze,
  output logic                     step_en,
  output logic [7:0]               LEDSEL,
  output logic [7:0]               LEDOUT
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int STEP_DIV = CLK_HZ / STEP_HZ;
  localparam int NUM_WIN  = DATA_W / 16;
  localparam int SCAN_W   = $clog2(SCAN_DIV);
  localparam int STEP_W   = $clog2(STEP_DIV);

  logic [SCAN_W-1:0] scan_cnt;
  logic [STEP_W-1:0] step_cnt;
  logic [2:0]        dig_idx;
  logic [31:0]       disp_reg;
  logic [15:0]       window;
  logic [3:0]        nibble;
  logic              scan_tick;
  logic              step_wrap;

  // Active-low segment pattern, dp kept off.
  function automatic logic [7:0] seg(input logic [3:0] n);
    case (n)
      4'h0: seg = 8'hC0;
      4'h1: seg = 8'hF9;
      4'h2: seg = 8'hA4;
      4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h92;
      4'h6: seg = 8'h82;
      4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;
      4'h9: seg = 8'h90;
      4'hA: seg = 8'h88;
      4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;
      4'hD: seg = 8'hA1;
      4'hE: seg = 8'h86;
      default: seg = 8'h8E;
    endcase
  endfunction

  // Channel range is checked first so a bad channel always reads DEAD,
  // regardless of the window select.
  always_comb begin
    window = 16'h0000;
    if (int'(ch_sel) >= NUM_CH) begin
      window = 16'hDEAD;
    end else if (int'(win_sel) >= NUM_WIN) begin
      window = 16'h0000;
    end else begin
      window = probe_bus[int'(ch_sel) * DATA_W + int'(win_sel) * 16 +: 16];
    end
  end

  // Digit 0 is the most significant nibble of disp_reg.
  always_comb begin
    nibble = disp_reg[4 * (7 - int'(dig_idx)) +: 4];
  end

  assign scan_tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
  assign step_wrap = (step_cnt == STEP_W'(STEP_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_reg <= 32'h0;
    end else if (!freeze) begin
      disp_reg <= {tag, window};
    end
  end

  // Scan: LEDSEL/LEDOUT only ever move together, on the tick edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      dig_idx  <= 3'd0;
      LEDSEL   <= 8'hFF;
      LEDOUT   <= 8'hFF;
    end else begin
      if (scan_tick) begin
        scan_cnt <= '0;
        LEDSEL   <= ~(8'b1 << dig_idx);
        LEDOUT   <= seg(nibble);
        dig_idx  <= dig_idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // step_en is high for the single cycle following the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt <= '0;
      step_en  <= 1'b0;
    end else begin
      step_en  <= step_wrap;
      step_cnt <= step_wrap ? '0 : step_cnt + 1'b1;
    end
  end

endmodule
